// File: rtl/logic_fold_pkg.sv
// Shared op codes, FSM state type and the bitwise op helper for logic_fold_unit.
// apply_op works on OP_MAX_W-bit values; callers cast to their own width (WIDTH <= OP_MAX_W).
package logic_fold_pkg;

  localparam int OP_MAX_W = 64;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  function automatic logic [OP_MAX_W-1:0] apply_op(
    input op_e                 op,
    input logic [OP_MAX_W-1:0] x,
    input logic [OP_MAX_W-1:0] y
  );
    logic [OP_MAX_W-1:0] r;
    r = {OP_MAX_W{1'b0}};
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NOT:  r = ~x;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      OP_RSVD: r = {OP_MAX_W{1'b0}};
      default: r = {OP_MAX_W{1'b0}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit logic op core; op codes are defined in logic_fold_pkg.
module logic_op_core
  import logic_fold_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] y_o
);

  // Zero-extended upper bits are discarded by the cast back to WIDTH.
  always_comb begin
    y_o = WIDTH'(apply_op(op_e'(op_i), OP_MAX_W'(x_i), OP_MAX_W'(y_i)));
  end

endmodule

// File: rtl/logic_fold_unit.sv
// One-deep output-registered logic stage: per-beat op or multi-beat fold over a valid/ready stream.
// Define LOGIC_FOLD_REDUCE_EN to add out_red = {^y, |y, &y} registered alongside out_y.
module logic_fold_unit
  import logic_fold_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] out_count
`ifdef LOGIC_FOLD_REDUCE_EN
  ,
  output logic [2:0]       out_red
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             accept_s;
  logic             emit_s;
  logic             fold_start_s;
  logic             fold_step_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [WIDTH-1:0] x_sel_s;
  logic [2:0]       op_sel_s;
  logic [WIDTH-1:0] op_y_s;

  // ACCUM beats also stall behind an unconsumed result.
  assign in_ready  = rst_n & (~out_valid_q | out_ready);
  assign accept_s  = in_valid & in_ready;
  assign x_sel_s   = (state_q == ST_ACCUM) ? acc_q : in_a;
  assign op_sel_s  = (state_q == ST_ACCUM) ? op_q : in_op;
  assign cnt_inc_s = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1'b1);

  logic_op_core #(
    .WIDTH (WIDTH)
  ) u_op_core (
    .op_i (op_sel_s),
    .x_i  (x_sel_s),
    .y_i  (in_b),
    .y_o  (op_y_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && in_acc && !in_last) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s && in_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode: which accepted beats start, step or emit a result
  always_comb begin
    emit_s       = 1'b0;
    fold_start_s = 1'b0;
    fold_step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          emit_s       = ~in_acc | in_last;
          fold_start_s = in_acc;
        end else begin
          emit_s       = 1'b0;
          fold_start_s = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          emit_s      = in_last;
          fold_step_s = 1'b1;
        end else begin
          emit_s      = 1'b0;
          fold_step_s = 1'b0;
        end
      end
      default: begin
        emit_s       = 1'b0;
        fold_start_s = 1'b0;
        fold_step_s  = 1'b0;
      end
    endcase
  end

  // Fold accumulator, beat counter and latched op
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    if (fold_start_s) begin
      acc_d = op_y_s;
      cnt_d = CNT_W'(1'b1);
      op_d  = in_op;
    end else if (fold_step_s) begin
      acc_d = op_y_s;
      cnt_d = cnt_inc_s;
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      op_d  = op_q;
    end
  end

  // Output register next state: load on emit, drop on handshake, else hold
  always_comb begin
    out_y_d     = out_y_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    if (emit_s) begin
      out_y_d     = op_y_s;
      out_count_d = fold_step_s ? cnt_inc_s : CNT_W'(1'b1);
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      op_q        <= OP_AND;
      out_valid_q <= 1'b0;
      out_y_q     <= {WIDTH{1'b0}};
      out_count_q <= {CNT_W{1'b0}};
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_count = out_count_q;

`ifdef LOGIC_FOLD_REDUCE_EN
  logic [2:0] out_red_q, out_red_d;

  assign out_red_d = emit_s ? {^op_y_s, |op_y_s, &op_y_s} : out_red_q;

  // Reduction flags track the value loaded into out_y
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_red_q <= 3'b000;
    end else begin
      out_red_q <= out_red_d;
    end
  end

  assign out_red = out_red_q;
`endif

endmodule
